// File: rtl/mem_pkg.sv
// Shared types and sizes for the instruction/data cache memory arbiter.
package mem_pkg;

  localparam int MEM_ADDR_W  = 28;
  localparam int MEM_BLOCK_W = 128;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-requester grant; MEM_ARB_RR_EN selects round-robin tie-break,
// otherwise the data cache always wins a tie.
module arb_pick
  import mem_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_owner_i,
`endif
  output logic grant_o,
  output logic owner_o
);

  always_comb begin
    grant_o = i_req_i | d_req_i;
    owner_o = d_req_i ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
    // On a tie, favour whichever side did not win the previous tie.
    if (i_req_i && d_req_i) begin
      owner_o = (last_owner_i == OWN_I) ? OWN_D : OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory between icache (read-only) and dcache (read/write),
// one transaction at a time. Optional round-robin ties via MEM_ARB_RR_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_BLOCK_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              op_write_q, op_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  logic d_req;
  logic grant_any;
  logic grant_owner;

  // A simultaneous read+write from the dcache is treated as a write.
  assign d_req = d_read | d_write;

  arb_pick u_pick (
    .i_req_i      (i_read),
    .d_req_i      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_owner_i (last_q),
`endif
    .grant_o      (grant_any),
    .owner_o      (grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_write_d  = op_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d     = ISSUE;
          owner_d     = grant_owner;
          op_write_d  = (grant_owner == OWN_D) && d_write;
          // Memory strobes are loaded here so they are already valid in ISSUE.
          mem_read_d  = ~op_write_d;
          mem_write_d = op_write_d;
          if (grant_owner == OWN_D) begin
            mem_addr_d  = d_address;
            mem_wdata_d = d_writedata;
          end else begin
            mem_addr_d  = i_address;
          end
`ifdef MEM_ARB_RR_EN
          if (i_read && d_req) begin
            last_d = grant_owner;
          end
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!mem_busywait) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!op_write_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = mem_readdata;
            end else begin
              i_rdata_d = mem_readdata;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      op_write_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= OWN_I;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_write_q  <= op_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Stall releases only in the owner's DONE cycle; an absent request never stalls.
  assign i_busywait = i_read && !((state_q == DONE) && (owner_q == OWN_I));
  assign d_busywait = d_req && !((state_q == DONE) && (owner_q == OWN_D));

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_addr_q;
  assign mem_writedata = mem_wdata_q;
  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;

endmodule
